if_id_buffer: RTL and testbench



---
 rtl/if_id_buffer_pkg.sv | 19 +
 rtl/if_id_buffer_fifo.sv | 75 +++++++
 rtl/if_id_buffer.sv | 80 ++++++++
 tb/tb_if_id_buffer.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/if_id_buffer_pkg.sv
// cpuDefine: types and constants shared by the IF, IF/ID buffer and ID stages.
//   FetchPkt  : one fetched packet {pc, inst, exc} at the core's native widths.
//   NOP_INST  : canonical no-op instruction word (andi r0, r0, 0).
//   ZERO_PC   : all-zero PC used when a stage presents no packet.
package cpuDefine;

  localparam int CORE_PC_W   = 32;
  localparam int CORE_INST_W = 32;

  typedef struct packed {
    logic [CORE_PC_W-1:0]   pc;
    logic [CORE_INST_W-1:0] inst;
    logic                   exc;
  } FetchPkt;

  localparam logic [CORE_INST_W-1:0] NOP_INST = 32'h0340_0000;
  localparam logic [CORE_PC_W-1:0]   ZERO_PC  = 32'h0000_0000;

endpackage

// File: rtl/if_id_buffer_fifo.sv
// sync_fifo: circular buffer with write/read pointers and an occupancy counter.
// Ports:
//   clk, reset  : clock, asynchronous active-high reset (pointers/count only)
//   push, wdata : write wdata at wr_ptr; caller only pushes when !full
//   pop         : advance rd_ptr; caller only pops when !empty
//   clear       : highest priority, empties the buffer and discards push/pop
//   rdata       : entry at rd_ptr (stale contents when empty)
//   count, full, empty : occupancy status decoded from registered count
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  input  logic                       clear,
  output logic [WIDTH-1:0]           rdata,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q,  count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // DEPTH is a power of two, so pointers wrap by plain overflow.
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is deliberately not reset; validity is tracked by count alone.
  always_ff @(posedge clk) begin
    if (push && !clear) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;
  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);

endmodule

// File: rtl/if_id_buffer.sv
// if_id_buffer: queues fetched packets between IF and ID so a fetch response
// arriving while ID stalls is kept rather than lost.
// Ports:
//   clk, reset                       : clock, asynchronous active-high reset
//   fetch_valid/pc/inst/exc, fetch_ready : packet in from IF
//   id_write_en                      : ID consumes the head entry
//   id_flush, if_flush               : hazard-unit flushes, either empties the buffer
//   id_valid/pc/inst/exc             : head entry to ID, zeroed when empty
//   count                            : occupancy, for debug/perf counters
//
// Handshake: a packet transfers into the buffer on a cycle where
// fetch_valid && fetch_ready, and out to ID on a cycle where
// id_valid && id_write_en. fetch_ready and id_valid are decoded from
// registered occupancy only; neither depends combinationally on any input.
// A flush discards both transfers of that cycle, and fetch_ready is not
// gated by it, so IF must drop its own packet on if_flush.
module if_id_buffer
  import cpuDefine::*;
#(
  parameter int DEPTH  = 2,
  parameter int PC_W   = 32,
  parameter int INST_W = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     fetch_valid,
  input  logic [PC_W-1:0]          fetch_pc,
  input  logic [INST_W-1:0]        fetch_inst,
  input  logic                     fetch_exc,
  output logic                     fetch_ready,
  input  logic                     id_write_en,
  input  logic                     id_flush,
  input  logic                     if_flush,
  output logic                     id_valid,
  output logic [PC_W-1:0]          id_pc,
  output logic [INST_W-1:0]        id_inst,
  output logic                     id_exc,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PKT_W = PC_W + INST_W + 1;

  logic             push;
  logic             pop;
  logic             flush;
  logic             full;
  logic             empty;
  logic [PKT_W-1:0] wr_pkt;
  logic [PKT_W-1:0] rd_pkt;

  assign flush  = id_flush | if_flush;
  assign wr_pkt = {fetch_pc, fetch_inst, fetch_exc};
  assign push   = fetch_valid && fetch_ready;
  assign pop    = id_valid && id_write_en;

  sync_fifo #(
    .WIDTH (PKT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .wdata (wr_pkt),
    .pop   (pop),
    .clear (flush),
    .rdata (rd_pkt),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  assign fetch_ready = !full;
  assign id_valid    = !empty;

  // Storage is never cleared, so stale head contents are masked off when empty.
  assign id_pc   = id_valid ? rd_pkt[PKT_W-1 -: PC_W]  : PC_W'(ZERO_PC);
  assign id_inst = id_valid ? rd_pkt[INST_W:1]         : '0;
  assign id_exc  = id_valid ? rd_pkt[0]                : 1'b0;

endmodule

// File: tb/tb_if_id_buffer.sv
module tb_if_id_buffer;

  localparam int DEPTH  = 2;
  localparam int PC_W   = 32;
  localparam int INST_W = 32;
  localparam int PKT_W  = PC_W + INST_W + 1;
  localparam int CNT_W  = $clog2(DEPTH) + 1;

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic              fetch_valid;
  logic [PC_W-1:0]   fetch_pc;
  logic [INST_W-1:0] fetch_inst;
  logic              fetch_exc;
  logic              fetch_ready;
  logic              id_write_en;
  logic              id_flush;
  logic              if_flush;
  logic              id_valid;
  logic [PC_W-1:0]   id_pc;
  logic [INST_W-1:0] id_inst;
  logic              id_exc;
  logic [CNT_W-1:0]  count;

  if_id_buffer #(.DEPTH(DEPTH), .PC_W(PC_W), .INST_W(INST_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .fetch_valid (fetch_valid),
    .fetch_pc    (fetch_pc),
    .fetch_inst  (fetch_inst),
    .fetch_exc   (fetch_exc),
    .fetch_ready (fetch_ready),
    .id_write_en (id_write_en),
    .id_flush    (id_flush),
    .if_flush    (if_flush),
    .id_valid    (id_valid),
    .id_pc       (id_pc),
    .id_inst     (id_inst),
    .id_exc      (id_exc),
    .count       (count)
  );

  // scoreboard
  logic [PKT_W-1:0] exp_q[$];
  int err_cnt = 0;
  int chk_cnt = 0;

  task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Model the handshakes seen in the current cycle, before the edge.
  task automatic sb_sample();
    logic [PKT_W-1:0] exp_pkt;
    if (reset) return;
    if (id_flush || if_flush) begin
      exp_q.delete();
      return;
    end
    if (id_valid && id_write_en) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_pop", 96'(id_valid), 96'(0));
      end else begin
        exp_pkt = exp_q.pop_front();
        check("sb_pkt", 96'({id_pc, id_inst, id_exc}), 96'(exp_pkt));
      end
    end
    if (fetch_valid && fetch_ready) exp_q.push_back({fetch_pc, fetch_inst, fetch_exc});
  endtask

  // driver: inputs change at posedge+1, sampling happens at negedge
  task automatic step();
    @(negedge clk);
    sb_sample();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_fetch(input logic v, input logic [PC_W-1:0] pc,
                             input logic [INST_W-1:0] inst, input logic exc);
    fetch_valid = v;
    fetch_pc    = pc;
    fetch_inst  = inst;
    fetch_exc   = exc;
  endtask

  task automatic check_empty_outputs(input string tag);
    check({tag, "_id_valid"}, 96'(id_valid), 96'(0));
    check({tag, "_id_pc"},    96'(id_pc),    96'(0));
    check({tag, "_id_inst"},  96'(id_inst),  96'(0));
    check({tag, "_id_exc"},   96'(id_exc),   96'(0));
    check({tag, "_count"},    96'(count),    96'(0));
  endtask

  initial begin
    int n;
    reset       = 1'b1;
    id_write_en = 1'b0;
    id_flush    = 1'b0;
    if_flush    = 1'b0;
    drive_fetch(1'b0, '0, '0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check_empty_outputs("reset");
    reset = 1'b0;
    step();
    check("reset_fetch_ready", 96'(fetch_ready), 96'(1));

    // empty pop is a no-op
    id_write_en = 1'b1;
    step();
    check("empty_pop_count", 96'(count), 96'(0));

    // single packet, count 0 -> 1 -> 0
    check("single_count0", 96'(count), 96'(0));
    drive_fetch(1'b1, 32'h1c00_0000, 32'h0280_0421, 1'b0);
    step();
    check("single_count1", 96'(count), 96'(1));
    check("single_valid",  96'(id_valid), 96'(1));
    check("single_pc",     96'(id_pc), 96'(32'h1c00_0000));
    check("single_inst",   96'(id_inst), 96'(32'h0280_0421));
    drive_fetch(1'b0, '0, '0, 1'b0);
    step();
    check("single_count2", 96'(count), 96'(0));

    // stream 8 packets with ID never stalling
    for (int i = 0; i < 8; i++) begin
      drive_fetch(1'b1, 32'h1c00_0100 + 32'(i * 4), $urandom, 1'($urandom_range(0, 1)));
      check("stream_ready", 96'(fetch_ready), 96'(1));
      step();
      check("stream_count", 96'(count), 96'(1));
    end
    drive_fetch(1'b0, '0, '0, 1'b0);
    step();
    check("stream_drained", 96'(count), 96'(0));

    // ID stall for 4 cycles while fetch keeps presenting
    id_write_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive_fetch(1'b1, 32'h1c00_0200 + 32'(i * 4), $urandom, 1'b0);
      step();
      check("stall_count", 96'(count), 96'((i + 1 < DEPTH) ? i + 1 : DEPTH));
      check("stall_ready", 96'(fetch_ready), 96'((i + 1 < DEPTH) ? 1 : 0));
    end
    drive_fetch(1'b0, '0, '0, 1'b0);
    id_write_en = 1'b1;
    n = 0;
    while (count != 0 && n < 8) begin
      step();
      n++;
    end
    check("stall_drain_count", 96'(count), 96'(0));
    check("stall_drain_cycles", 96'(n), 96'(DEPTH));
    check("stall_sb_empty", 96'(exp_q.size()), 96'(0));

    // full buffer, flush with push and pop in the same cycle
    id_write_en = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      drive_fetch(1'b1, 32'h1c00_0300 + 32'(i * 4), $urandom, 1'b0);
      step();
    end
    check("full_count", 96'(count), 96'(DEPTH));
    check("full_ready", 96'(fetch_ready), 96'(0));
    drive_fetch(1'b1, 32'h1c00_0dea, 32'hdead_beef, 1'b0);
    id_write_en = 1'b1;
    id_flush    = 1'b1;
    check("flush_ready_ungated", 96'(fetch_ready), 96'(0));
    step();
    id_flush = 1'b0;
    drive_fetch(1'b0, '0, '0, 1'b0);
    check("flush_count", 96'(count), 96'(0));
    check("flush_valid", 96'(id_valid), 96'(0));
    check("flush_inst",  96'(id_inst), 96'(0));
    check("flush_ready", 96'(fetch_ready), 96'(1));
    repeat (2) step();

    // if_flush, then a push the cycle after is visible one cycle later
    id_write_en = 1'b0;
    drive_fetch(1'b1, 32'h1c00_0400, 32'h1111_1111, 1'b0);
    step();
    if_flush = 1'b1;
    drive_fetch(1'b1, 32'h1c00_0404, 32'h2222_2222, 1'b0);
    step();
    if_flush = 1'b0;
    check("if_flush_valid", 96'(id_valid), 96'(0));
    drive_fetch(1'b1, 32'h1c00_0408, 32'h3333_3333, 1'b0);
    step();
    drive_fetch(1'b0, '0, '0, 1'b0);
    check("post_flush_valid", 96'(id_valid), 96'(1));
    check("post_flush_pc", 96'(id_pc), 96'(32'h1c00_0408));
    id_write_en = 1'b1;
    step();

    // exception flag follows exactly its own entry
    id_write_en = 1'b0;
    drive_fetch(1'b1, 32'h1c00_0003, 32'h0000_0000, 1'b1);
    step();
    drive_fetch(1'b1, 32'h1c00_0008, 32'h0280_0421, 1'b0);
    step();
    drive_fetch(1'b0, '0, '0, 1'b0);
    check("exc_head_pc", 96'(id_pc), 96'(32'h1c00_0003));
    check("exc_head",    96'(id_exc), 96'(1));
    id_write_en = 1'b1;
    step();
    check("exc_next_pc", 96'(id_pc), 96'(32'h1c00_0008));
    check("exc_next",    96'(id_exc), 96'(0));
    step();

    // asynchronous reset mid-cycle with entries held
    id_write_en = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      drive_fetch(1'b1, 32'h1c00_0500 + 32'(i * 4), 32'h5555_0000 + 32'(i), 1'b0);
      step();
    end
    drive_fetch(1'b0, '0, '0, 1'b0);
    check("pre_reset_count", 96'(count), 96'(DEPTH));
    #2;
    reset = 1'b1;
    #1;
    check_empty_outputs("async_reset");
    exp_q.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
    step();
    check("post_reset_ready", 96'(fetch_ready), 96'(1));
    check("post_reset_count", 96'(count), 96'(0));
    check("final_sb_empty", 96'(exp_q.size()), 96'(0));

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

  // hard time limit so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end

endmodule
